// File: rtl/uart_rx_fifo_if.sv
// Consumer-side handshake of the UART receiver: show-ahead FIFO head plus
// per-entry error flags, popped with valid/ready.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] dout;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_error;
    logic                 framing_error;

    modport master (
        output dout, data_valid, parity_error, framing_error,
        input  data_ready
    );

    modport slave (
        input  dout, data_valid, parity_error, framing_error,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised async serial receiver: 16x oversampling, 3-sample majority vote,
// configurable data/parity/stop bits, received words queued in a show-ahead FIFO.
module uart_rx_fifo #(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 19200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_EN     = 1,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_in,
    input  logic           odd,
    uart_rx_fifo_if.master m_if,
    output logic           overrun,
    output logic           busy
);
    localparam int TICK_DIV = CLK_FREQUENCY / (BAUD_RATE * 16);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int EW       = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH
    } state_t;

    state_t               r_state, w_state_next;
    logic                 r_sync1, r_sync2, w_rxs;
    logic [TW-1:0]        r_tick_cnt;
    logic [3:0]           r_samp_cnt;
    logic [1:0]           r_samp;
    logic                 w_tick, w_decide, w_bit;
    logic [DATA_BITS-1:0] r_data;
    logic [3:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_perr, r_ferr;

    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_overrun;
    logic                 w_push, w_pop, w_wr, w_full, w_valid;
    logic [EW-1:0]        w_entry, w_head;

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rxs = r_sync2;

    // Bit timing restarts from zero on every start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_samp_cnt <= '0;
            r_samp     <= '0;
        end else if (r_state == S_IDLE) begin
            r_tick_cnt <= '0;
            r_samp_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (w_tick) begin
                r_samp_cnt <= r_samp_cnt + 4'd1;
                if (r_samp_cnt == 4'd7) r_samp[0] <= w_rxs;
                if (r_samp_cnt == 4'd8) r_samp[1] <= w_rxs;
            end
        end
    end

    assign w_tick   = (r_state != S_IDLE) && (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_decide = w_tick && (r_samp_cnt == 4'd9);
    assign w_bit    = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rxs) | (r_samp[1] & w_rxs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: the next state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:   if (!w_rxs) w_state_next = S_START;
            S_START:  if (w_decide) w_state_next = w_bit ? S_IDLE : S_DATA;
            S_DATA:   if (w_decide && r_bit_cnt == 4'(DATA_BITS - 1))
                          w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_decide) w_state_next = S_STOP;
            S_STOP:   if (w_decide && r_stop_cnt == 1'(STOP_BITS - 1))
                          w_state_next = S_PUSH;
            S_PUSH:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else if (w_decide) begin
            unique case (r_state)
                S_START: begin
                    r_bit_cnt  <= '0;
                    r_stop_cnt <= 1'b0;
                    r_perr     <= 1'b0;
                    r_ferr     <= 1'b0;
                end
                S_DATA: begin
                    r_data    <= {w_bit, r_data[DATA_BITS-1:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                S_PARITY: r_perr <= (w_bit != (^r_data ^ odd));
                S_STOP: begin
                    if (!w_bit) r_ferr <= 1'b1;
                    r_stop_cnt <= r_stop_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_push  = (r_state == S_PUSH);
    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = w_valid && m_if.data_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_entry = {r_data, r_perr, r_ferr};

    // NOTE: storage is not reset; entries are only observable through w_valid,
    // so clearing them would add reset fan-out for no functional gain.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
            r_overrun <= w_push && !w_wr;
        end
    end

    assign w_head             = r_mem[r_rd_ptr];
    assign m_if.data_valid    = w_valid;
    assign m_if.dout          = w_valid ? w_head[EW-1:2] : '0;
    assign m_if.parity_error  = w_valid & w_head[1];
    assign m_if.framing_error = w_valid & w_head[0];
    assign overrun            = r_overrun;
    assign busy               = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed and randomized frames compared
// against a queue-based model of the expected received words.
module tb_uart_rx_fifo;
    localparam int CLK_FREQUENCY = 1600000;
    localparam int BAUD_RATE     = 10000;
    localparam int DATA_BITS     = 8;
    localparam int FIFO_DEPTH    = 4;
    localparam int BIT_CLKS      = CLK_FREQUENCY / BAUD_RATE;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_in = 1'b1;
    logic odd = 1'b0;
    logic overrun, busy;

    uart_rx_fifo_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    uart_rx_fifo #(
        .CLK_FREQUENCY(CLK_FREQUENCY),
        .BAUD_RATE    (BAUD_RATE),
        .DATA_BITS    (DATA_BITS),
        .PARITY_EN    (1),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_in  (rx_in),
        .odd    (odd),
        .m_if   (rx_if.master),
        .overrun(overrun),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    entry_t exp_q[$];
    entry_t mon_e;
    int     n_checks = 0;
    int     n_errors = 0;
    int     ovr_seen = 0;
    int     ovr_exp  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer side: every pop is compared with the oldest expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (overrun) ovr_seen++;
            if (rx_if.data_valid && rx_if.data_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(rx_if.data_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dout", 32'(rx_if.dout), 32'(mon_e.data));
                    check("parity_error", 32'(rx_if.parity_error), 32'(mon_e.perr));
                    check("framing_error", 32'(rx_if.framing_error), 32'(mon_e.ferr));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        step(BIT_CLKS);
    endtask

    // Model: a completed frame enters the FIFO if there is room, else it is an overrun.
    task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad);
        entry_t e;
        e.data = d;
        e.perr = par_bad;
        e.ferr = stop_bad;
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(e);
        else                           ovr_exp++;
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
        drive_bit((^d) ^ odd ^ par_bad);
        drive_bit(!stop_bad);
        rx_in = 1'b1;
        step(100 + $urandom_range(0, 40));
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) step(1);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rx_if.data_ready = 1'b0;
        step(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(rx_if.data_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_dout", 32'(rx_if.dout), 32'd0);
        check("rst_perr", 32'(rx_if.parity_error), 32'd0);
        check("rst_ferr", 32'(rx_if.framing_error), 32'd0);
        rst = 1'b0;
        step(20);
        rx_if.data_ready = 1'b1;

        odd = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0);
        wait_drain("good_frame_drain");
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_drain("parity_frame_drain");
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0);
        wait_drain("framing_frame_drain");

        rx_in = 1'b0;
        step(40);
        rx_in = 1'b1;
        for (int i = 0; i < 200 && busy; i++) step(1);
        check("glitch_busy", 32'(busy), 32'd0);
        step(300);
        check("glitch_valid", 32'(rx_if.data_valid), 32'd0);

        rx_if.data_ready = 1'b0;
        odd = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
        step(50);
        check("full_valid", 32'(rx_if.data_valid), 32'd1);
        check("overrun_pulses", 32'(ovr_seen), 32'(ovr_exp));
        rx_if.data_ready = 1'b1;
        wait_drain("overrun_drain");
        step(2);
        check("empty_after_drain", 32'(rx_if.data_valid), 32'd0);

        repeat (6) begin
            odd = 1'($urandom_range(0, 1));
            send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            wait_drain("random_drain");
        end

        odd = 1'b1;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        step(80);
        rst = 1'b1;
        #1;
        check("midframe_rst_busy", 32'(busy), 32'd0);
        check("midframe_rst_valid", 32'(rx_if.data_valid), 32'd0);
        rx_in = 1'b1;
        step(3);
        rst = 1'b0;
        step(300);
        send_frame(8'h96, 1'b0, 1'b0);
        wait_drain("post_reset_drain");
        check("overrun_total", 32'(ovr_seen), 32'(ovr_exp));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
